upsampling_row_expander: RTL and testbench

UPSAMPLING_ROW_EXPANDER -- requirements
Module: upsampling_row_expander

---
 rtl/upsampling_row_expander_pkg.sv | 25 ++
 rtl/upsampling_line_buffer.sv | 51 +++++
 rtl/upsampling_row_expander.sv | 184 ++++++++++++++++++
 tb/tb_upsampling_row_expander.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/upsampling_row_expander_pkg.sv
// Shared definitions for the 2x nearest-neighbour row expander.
// Holds the default geometry constants and the control FSM state encoding
// used by upsampling_row_expander and its line buffer.
package upsampling_row_expander_pkg;

  // Default bits per pixel word.
  localparam int unsigned UPS_WIDTH     = 128;
  // Default width of the column/row counts (line buffer depth is 2**ADDR_BITS).
  localparam int unsigned UPS_ADDR_BITS = 10;

  // Control FSM states.
  //   IDLE     : waiting for an accepted start
  //   WAIT_ROW : waiting for the read FIFO to hold a full input row
  //   LOAD     : streaming one input row into the line buffer
  //   EMIT     : two passes over the buffered row, each pixel doubled
  //   DONE     : end-of-map handshake
  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    WAIT_ROW = 3'd1,
    LOAD     = 3'd2,
    EMIT     = 3'd3,
    DONE     = 3'd4
  } ups_state_e;

endpackage

// File: rtl/upsampling_line_buffer.sv
// Single-row storage for the row expander.
// Simple dual-port RAM: one write port, one read port, depth 2**ADDR_BITS,
// WIDTH bits per word, one-cycle registered read.
// Ports:
//   clk_i     : clock, rising edge
//   rst_ni    : asynchronous active-low reset (read register only; the
//               memory array itself is never cleared)
//   wr_en_i   : write strobe
//   wr_addr_i : write address
//   wr_data_i : write data
//   rd_en_i   : read strobe; rd_data_o updates on the following edge
//   rd_addr_i : read address
//   rd_data_o : registered read data, holds between reads
module upsampling_line_buffer #(
  parameter int unsigned WIDTH     = 128,
  parameter int unsigned ADDR_BITS = 10
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 wr_en_i,
  input  logic [ADDR_BITS-1:0] wr_addr_i,
  input  logic [WIDTH-1:0]     wr_data_i,
  input  logic                 rd_en_i,
  input  logic [ADDR_BITS-1:0] rd_addr_i,
  output logic [WIDTH-1:0]     rd_data_o
);

  localparam int unsigned DEPTH = 1 << ADDR_BITS;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] rd_data_q;

  // Storage array: no reset so it maps onto block RAM.
  always_ff @(posedge clk_i) begin
    if (wr_en_i) begin
      mem[wr_addr_i] <= wr_data_i;
    end
  end

  // Output register is resettable so the expander's dout reads zero in reset.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_data_q <= '0;
    end else if (rd_en_i) begin
      rd_data_q <= mem[rd_addr_i];
    end
  end

  assign rd_data_o = rd_data_q;

endmodule

// File: rtl/upsampling_row_expander.sv
// 2x nearest-neighbour upsampler for a feature map streamed row by row.
// Each input row is pulled from a read FIFO into a line buffer, then emitted
// twice; within each emitted row every pixel appears twice consecutively.
// Ports:
//   clk        : clock, rising edge
//   rst        : asynchronous active-low reset
//   start      : one-cycle pulse starting a map (honoured only when idle)
//   col_num    : input pixels per row, latched at accepted start
//   row_num    : input rows per map, latched at accepted start
//   M_count    : words requested from the read FIFO ({1'b0, latched col_num})
//   M_Ready    : read FIFO holds at least M_count words
//   fifo_rd_en : read strobe to the read FIFO
//   fifo_dout  : read FIFO data, valid the cycle after fifo_rd_en
//   S_Ready    : downstream can accept a word this cycle
//   dout       : upsampled pixel word
//   dout_valid : dout valid this cycle
//   busy       : high whenever the FSM is not idle
//   done       : one-cycle pulse one cycle after the last output word
module upsampling_row_expander
  import upsampling_row_expander_pkg::*;
#(
  parameter int unsigned WIDTH     = UPS_WIDTH,
  parameter int unsigned ADDR_BITS = UPS_ADDR_BITS
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [ADDR_BITS-1:0] col_num,
  input  logic [ADDR_BITS-1:0] row_num,
  output logic [ADDR_BITS:0]   M_count,
  input  logic                 M_Ready,
  output logic                 fifo_rd_en,
  input  logic [WIDTH-1:0]     fifo_dout,
  input  logic                 S_Ready,
  output logic [WIDTH-1:0]     dout,
  output logic                 dout_valid,
  output logic                 busy,
  output logic                 done
);

  ups_state_e             state_q;
  logic [ADDR_BITS-1:0]   col_q;        // latched col_num
  logic [ADDR_BITS-1:0]   row_q;        // latched row_num
  logic [ADDR_BITS-1:0]   rd_cnt_q;     // FIFO reads issued in this row
  logic [ADDR_BITS-1:0]   wr_cnt_q;     // line-buffer write address
  logic                   fifo_rd_en_q;
  logic                   rd_pend_q;    // FIFO word arrives this cycle
  logic [ADDR_BITS-1:0]   pix_q;        // EMIT read address
  logic                   dup_q;        // second copy of current pixel
  logic                   pass_q;       // second pass over the row
  logic [ADDR_BITS-1:0]   row_cnt_q;
  logic                   dout_valid_q;
  logic                   done_q;

  logic [ADDR_BITS-1:0]   col_last;
  logic [ADDR_BITS-1:0]   row_last;
  logic                   lb_rd_en;
  logic                   start_ok;

  // Compare against count-1 so a full-scale count never wraps the counter.
  assign col_last = col_q - ADDR_BITS'(1);
  assign row_last = row_q - ADDR_BITS'(1);

  assign start_ok = start && (col_num != '0) && (row_num != '0);

  // A read is issued every EMIT cycle the consumer can take a word; the word
  // appears on dout one cycle later, tracked by dout_valid_q.
  assign lb_rd_en = (state_q == EMIT) && S_Ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= IDLE;
      col_q        <= '0;
      row_q        <= '0;
      rd_cnt_q     <= '0;
      wr_cnt_q     <= '0;
      fifo_rd_en_q <= 1'b0;
      rd_pend_q    <= 1'b0;
      pix_q        <= '0;
      dup_q        <= 1'b0;
      pass_q       <= 1'b0;
      row_cnt_q    <= '0;
      dout_valid_q <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      done_q       <= 1'b0;
      dout_valid_q <= lb_rd_en;
      rd_pend_q    <= fifo_rd_en_q;

      case (state_q)
        IDLE: begin
          if (start_ok) begin
            col_q     <= col_num;
            row_q     <= row_num;
            row_cnt_q <= '0;
            state_q   <= WAIT_ROW;
          end
        end

        WAIT_ROW: begin
          if (M_Ready) begin
            state_q      <= LOAD;
            fifo_rd_en_q <= 1'b1;
            rd_cnt_q     <= '0;
            wr_cnt_q     <= '0;
          end
        end

        LOAD: begin
          // Read strobe and write side run one cycle apart; the state ends
          // only once the final returned word has been written.
          if (fifo_rd_en_q) begin
            if (rd_cnt_q == col_last) begin
              fifo_rd_en_q <= 1'b0;
            end else begin
              rd_cnt_q <= rd_cnt_q + ADDR_BITS'(1);
            end
          end
          if (rd_pend_q) begin
            if (wr_cnt_q == col_last) begin
              state_q <= EMIT;
              pix_q   <= '0;
              dup_q   <= 1'b0;
              pass_q  <= 1'b0;
            end else begin
              wr_cnt_q <= wr_cnt_q + ADDR_BITS'(1);
            end
          end
        end

        EMIT: begin
          if (S_Ready) begin
            if (!dup_q) begin
              dup_q <= 1'b1;
            end else begin
              dup_q <= 1'b0;
              if (pix_q == col_last) begin
                pix_q <= '0;
                if (!pass_q) begin
                  pass_q <= 1'b1;
                end else begin
                  pass_q    <= 1'b0;
                  row_cnt_q <= row_cnt_q + ADDR_BITS'(1);
                  state_q   <= (row_cnt_q == row_last) ? DONE : WAIT_ROW;
                end
              end else begin
                pix_q <= pix_q + ADDR_BITS'(1);
              end
            end
          end
        end

        DONE: begin
          // The final word is on dout this cycle; done lands on the next.
          done_q  <= 1'b1;
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  upsampling_line_buffer #(
    .WIDTH     (WIDTH),
    .ADDR_BITS (ADDR_BITS)
  ) u_line_buffer (
    .clk_i     (clk),
    .rst_ni    (rst),
    .wr_en_i   (rd_pend_q),
    .wr_addr_i (wr_cnt_q),
    .wr_data_i (fifo_dout),
    .rd_en_i   (lb_rd_en),
    .rd_addr_i (pix_q),
    .rd_data_o (dout)
  );

  assign M_count    = {1'b0, col_q};
  assign fifo_rd_en = fifo_rd_en_q;
  assign dout_valid = dout_valid_q;
  assign busy       = (state_q != IDLE);
  assign done       = done_q;

endmodule

// File: tb/tb_upsampling_row_expander.sv
module tb_upsampling_row_expander;

  localparam int W  = 128;
  localparam int AB = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [AB-1:0] col_num = '0;
  logic [AB-1:0] row_num = '0;
  logic [AB:0]   M_count;
  logic          M_Ready = 1'b0;
  logic          fifo_rd_en;
  logic [W-1:0]  fifo_dout = '0;
  logic          S_Ready = 1'b1;
  logic [W-1:0]  dout;
  logic          dout_valid;
  logic          busy;
  logic          done;

  upsampling_row_expander #(
    .WIDTH     (W),
    .ADDR_BITS (AB)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .col_num    (col_num),
    .row_num    (row_num),
    .M_count    (M_count),
    .M_Ready    (M_Ready),
    .fifo_rd_en (fifo_rd_en),
    .fifo_dout  (fifo_dout),
    .S_Ready    (S_Ready),
    .dout       (dout),
    .dout_valid (dout_valid),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [W-1:0] rand_word();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Read FIFO model: data appears the cycle after a sampled read strobe.
  logic [W-1:0] fifo_q[$];
  logic [W-1:0] exp_q[$];
  bit           mr_block = 1'b0;
  bit           rd_seen  = 1'b0;

  always @(negedge clk) rd_seen = fifo_rd_en;

  always @(posedge clk) begin
    #2;
    if (rd_seen) begin
      if (fifo_q.size() > 0) fifo_dout = fifo_q.pop_front();
      else check("fifo_underrun", 1, 0);
    end
    M_Ready = !mr_block && (fifo_q.size() >= int'(M_count));
  end

  // Output monitor: compares every valid word against the expected stream.
  bit mon_on = 1'b0;
  bit prev_sr = 1'b1;
  int cyc, nvalid, nrd, ndone, nbusy, last_valid_cyc, done_cyc, first_rd_cyc;

  always @(negedge clk) begin
    if (mon_on) begin
      cyc++;
      if (busy) nbusy++;
      if (fifo_rd_en) begin
        nrd++;
        if (first_rd_cyc < 0) first_rd_cyc = cyc;
      end
      if (!prev_sr) check("stall_no_valid", dout_valid, 0);
      if (dout_valid) begin
        nvalid++;
        last_valid_cyc = cyc;
        if (exp_q.size() == 0) check("extra_valid", 1, 0);
        else check("dout", dout, exp_q.pop_front());
      end
      if (done) begin
        ndone++;
        done_cyc = cyc;
      end
      prev_sr = S_Ready;
    end
  end

  task automatic mon_clear();
    cyc = 0; nvalid = 0; nrd = 0; ndone = 0; nbusy = 0;
    last_valid_cyc = -1; done_cyc = -1; first_rd_cyc = -1;
    prev_sr = 1'b1;
  endtask

  // Reference: every row twice, every pixel twice within a row.
  task automatic load_map(input int col, input int row);
    logic [W-1:0] words[$];
    for (int i = 0; i < col * row; i++) begin
      words.push_back(rand_word());
      fifo_q.push_back(words[i]);
    end
    for (int r = 0; r < row; r++)
      for (int p = 0; p < 2; p++)
        for (int c = 0; c < col; c++) begin
          exp_q.push_back(words[r * col + c]);
          exp_q.push_back(words[r * col + c]);
        end
  endtask

  task automatic pulse_start(input int col, input int row);
    @(posedge clk); #1;
    start = 1'b1; col_num = AB'(col); row_num = AB'(row);
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // sr_mode: 0 S_Ready always high, 1 random, 2 one 3-cycle stall mid-pass.
  task automatic run_map(input int col, input int row, input int sr_mode, input int mr_wait);
    int budget = 20 * col * row + 100;
    int stall_left = 3;
    int release_cyc = -1;
    load_map(col, row);
    mon_clear();
    S_Ready  = 1'b1;
    mr_block = (mr_wait > 0);
    mon_on   = 1'b1;
    pulse_start(col, row);
    for (int k = 0; k < budget && done_cyc < 0; k++) begin
      // Start and count changes while busy must be ignored.
      if (k == 2) begin
        start = 1'b1; col_num = AB'($urandom); row_num = AB'($urandom);
      end
      if (k == 3) start = 1'b0;
      if (mr_wait > 0 && k == mr_wait - 1) begin
        mr_block = 1'b0;
        release_cyc = cyc + 1;
      end
      case (sr_mode)
        1: S_Ready = ($urandom % 3) != 0;
        2: if (nvalid >= 6 && stall_left > 0) begin
             S_Ready = 1'b0; stall_left--;
           end else S_Ready = 1'b1;
        default: S_Ready = 1'b1;
      endcase
      @(posedge clk); #1;
    end
    S_Ready = 1'b1;
    if (done_cyc < 0) begin
      check("done_timeout", 0, 1);
    end else begin
      check("done_lag", done_cyc - last_valid_cyc, 1);
    end
    repeat (3) @(posedge clk);
    #1;
    check("n_valid", nvalid, 4 * col * row);
    check("n_fifo_rd", nrd, col * row);
    check("exp_left", exp_q.size(), 0);
    check("done_pulses", ndone, 1);
    check("busy_after", busy, 0);
    check("m_count", M_count, col);
    if (mr_wait > 0) check("load_after_mready", first_rd_cyc - release_cyc, 1);
    mon_on = 1'b0;
    fifo_q.delete();
    exp_q.delete();
  endtask

  task automatic zero_start(input int col, input int row);
    mon_clear();
    mon_on = 1'b1;
    pulse_start(col, row);
    repeat (15) @(posedge clk);
    #1;
    check("zero_busy", nbusy, 0);
    check("zero_rd", nrd, 0);
    check("zero_done", ndone, 0);
    mon_on = 1'b0;
  endtask

  task automatic reset_outputs(input string tag);
    check({tag, "_rd_en"}, fifo_rd_en, 0);
    check({tag, "_valid"}, dout_valid, 0);
    check({tag, "_dout"}, dout, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_done"}, done, 0);
    check({tag, "_mcount"}, M_count, 0);
  endtask

  initial begin
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_outputs("rst");
    rst = 1'b1;

    run_map(4, 2, 0, 0);
    run_map(1, 1, 0, 0);
    run_map(4, 2, 2, 0);
    run_map(3, 2, 0, 10);

    // Reset in the middle of row 1 of a 3-row map.
    begin
      int k = 0;
      load_map(3, 3);
      mon_clear();
      mon_on = 1'b1;
      pulse_start(3, 3);
      while (nvalid < 14 && k < 500) begin
        @(posedge clk); #1;
        k++;
      end
      check("pre_reset_progress", nvalid >= 14, 1);
      mon_on = 1'b0;
      @(posedge clk); #3;
      rst = 1'b0;
      #1;
      reset_outputs("midrst");
      fifo_q.delete();
      exp_q.delete();
      @(posedge clk); #1;
      rst = 1'b1;
    end
    run_map(2, 1, 0, 0);

    zero_start(0, 5);
    zero_start(5, 0);

    run_map(1023, 1, 0, 0);

    for (int i = 0; i < 6; i++)
      run_map(int'($urandom_range(6, 1)), int'($urandom_range(3, 1)), 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
